// File: rtl/four_bit_deserializer_pkg.sv
// rtl/four_bit_deserializer_pkg.sv - shared constants and types for the serial-in deserializer
// Purpose: default word width, FSM state encoding and bit-order encoding.
package four_bit_deserializer_pkg;

   localparam int unsigned WIDTH_DEFAULT = 4;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   localparam logic LSB_FIRST = 1'b1;
   localparam logic MSB_FIRST = 1'b0;

endpackage

// File: rtl/shift_in_register.sv
// rtl/shift_in_register.sv - serial-in shift register with selectable bit order
// Purpose: holds the partially assembled word and shifts one bit in per enable.
// Ports:
//   clock   - rising-edge clock
//   reset   - synchronous active-low reset, clears the register
//   enable  - shift one bit in this cycle
//   order   - LSB_FIRST shifts right (new bit at MSB), MSB_FIRST shifts left
//   bit_in  - serial bit
//   sr_next - value the register takes on the next edge (includes bit_in when enabled)
module shift_in_register
   import four_bit_deserializer_pkg::*;
#(
   parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             enable,
   input  logic             order,
   input  logic             bit_in,
   output logic [WIDTH-1:0] sr_next
);

   logic [WIDTH-1:0] sr;
   logic [WIDTH-1:0] shifted;

   always_comb begin
      shifted = sr;
      if (order == LSB_FIRST) begin
         shifted = {bit_in, sr[WIDTH-1:1]};
      end else begin
         shifted = {sr[WIDTH-2:0], bit_in};
      end
   end

   // Exposing the next value lets the top capture a completed word on the
   // same edge that samples its last bit.
   assign sr_next = enable ? shifted : sr;

   always_ff @(posedge clock) begin
      if (!reset) begin
         sr <= '0;
      end else begin
         sr <= sr_next;
      end
   end

endmodule

// File: rtl/four_bit_deserializer.sv
// rtl/four_bit_deserializer.sv - serial-in parallel-out receiver with valid/ready output
// Purpose: assembles WIDTH serial bits into a word and holds it for a consumer.
// Ports:
//   clock        - rising-edge clock
//   reset        - synchronous active-low reset
//   serial_in    - serial data bit, sampled when serial_valid is high
//   serial_valid - qualifies serial_in
//   right_shift  - bit order, latched at the first bit of each word (1 = LSB-first)
//   data_out     - last delivered word, stable while data_valid is high
//   data_valid   - data_out holds an undelivered word
//   data_ready   - consumer accepts the word when data_valid is also high
//   busy         - a word is partially received
//   overrun      - sticky: a completed word was dropped
module four_bit_deserializer
   import four_bit_deserializer_pkg::*;
#(
   parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             serial_in,
   input  logic             serial_valid,
   input  logic             right_shift,
   output logic [WIDTH-1:0] data_out,
   output logic             data_valid,
   input  logic             data_ready,
   output logic             busy,
   output logic             overrun
);

   localparam int unsigned CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

   state_t           state_q;
   state_t           state_d;
   logic             order_q;
   logic             order_eff;
   logic [CW-1:0]    bit_count_q;
   logic             word_done;
   logic             accept;
   logic [WIDTH-1:0] sr_next;
   logic [WIDTH-1:0] data_out_q;
   logic             data_valid_q;
   logic             overrun_q;

   // The first bit of a word must already use the new order, before order_q
   // has captured it.
   assign order_eff = (state_q == IDLE) ? right_shift : order_q;
   assign accept    = data_valid_q & data_ready;

   shift_in_register #(
      .WIDTH (WIDTH)
   ) u_shift_in_register (
      .clock   (clock),
      .reset   (reset),
      .enable  (serial_valid),
      .order   (order_eff),
      .bit_in  (serial_in),
      .sr_next (sr_next)
   );

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      word_done = 1'b0;
      case (state_q)
         IDLE: begin
            if (serial_valid) begin
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            if (serial_valid && (bit_count_q == LAST_COUNT)) begin
               word_done = 1'b1;
               state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         order_q      <= LSB_FIRST;
         bit_count_q  <= '0;
         data_out_q   <= '0;
         data_valid_q <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         if ((state_q == IDLE) && serial_valid) begin
            order_q <= right_shift;
         end

         if (serial_valid) begin
            bit_count_q <= word_done ? '0 : bit_count_q + CW'(1);
         end

         if (word_done) begin
            // A held word that is not being accepted this cycle wins; the new
            // word is lost.
            if (data_valid_q && !data_ready) begin
               overrun_q <= 1'b1;
            end else begin
               data_out_q   <= sr_next;
               data_valid_q <= 1'b1;
            end
         end else if (accept) begin
            data_valid_q <= 1'b0;
         end
      end
   end

   assign data_out   = data_out_q;
   assign data_valid = data_valid_q;
   assign busy       = (state_q == SHIFT);
   assign overrun    = overrun_q;

endmodule
